// File: rtl/seq_divider_ctrl_16_if.sv
// seq_divider_ctrl_16_if
// Handshake and operand/result bundle for the sequential 16-bit divider.
//   start     : request pulse, sampled only while the divider is idle
//   dividend  : 16-bit unsigned dividend, captured with start
//   divisor   : 16-bit unsigned divisor, captured with start
//   busy      : high while a division is iterating or completing
//   done      : one-cycle pulse, results valid
//   dbz       : divide-by-zero flag, valid with done
//   quotient  : result quotient, held until the next accepted start
//   remainder : result remainder, held until the next accepted start
// master = requester (drives operands), slave = divider.
interface seq_divider_ctrl_16_if;
   logic        start;
   logic [15:0] dividend;
   logic [15:0] divisor;
   logic        busy;
   logic        done;
   logic        dbz;
   logic [15:0] quotient;
   logic [15:0] remainder;

   modport master (
      output start, dividend, divisor,
      input  busy, done, dbz, quotient, remainder
   );

   modport slave (
      input  start, dividend, divisor,
      output busy, done, dbz, quotient, remainder
   );
endinterface

// File: rtl/seq_divider_ctrl_16.sv
// seq_divider_ctrl_16
// Multi-cycle restoring divider (16-bit unsigned / 16-bit unsigned).
// The divisor is aligned into the upper half of a 32-bit register and shifted
// right once per iteration; each iteration tries a subtract from the 32-bit
// remainder and shifts a quotient bit in. 17 iterations, then a one-cycle DONE.
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous, active-high reset
//   bus   : seq_divider_ctrl_16_if.slave (start/operands in, busy/done/results out)
//
// state  | meaning
// -------+-----------------------------------------------------------
// S_IDLE | waiting for start; results from last operation held
// S_ITER | one subtract/test/restore/shift step per cycle (17 total)
// S_DONE | results valid, done pulse; returns to S_IDLE
module seq_divider_ctrl_16 #(
   parameter logic [15:0] DBZ_QUOT = 16'hFFFF,
   parameter int          ITERS    = 17
) (
   input logic                   clk,
   input logic                   reset,
   seq_divider_ctrl_16_if.slave  bus
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_ITER = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t      r_state;
   state_t      w_state_nxt;

   logic [31:0] r_rem;
   logic [31:0] r_div;
   logic [16:0] r_q;
   logic [4:0]  r_cnt;
   logic [15:0] r_quot;
   logic [15:0] r_remd;
   logic        r_dbz;

   logic [32:0] w_diff;
   logic [31:0] w_rem_nxt;
   logic [16:0] w_q_nxt;
   logic        w_last;
   logic        w_busy;
   logic        w_done;

   // Divisor alignment: places the divisor in the upper half of the 32-bit
   // divisor register.
   function automatic logic [31:0] zero_shifter_16(input logic [15:0] a);
      return {a, 16'b0};
   endfunction

   // 33-bit subtract; bit 32 set means the trial went negative and the
   // remainder is kept (restored) instead of updated.
   always_comb begin
      w_diff    = {1'b0, r_rem} - {1'b0, r_div};
      w_rem_nxt = r_rem;
      w_q_nxt   = {r_q[15:0], 1'b0};
      if (!w_diff[32]) begin
         w_rem_nxt = w_diff[31:0];
         w_q_nxt   = {r_q[15:0], 1'b1};
      end
   end

   assign w_last = (r_cnt == 5'(ITERS - 1));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: begin
            if (bus.start) begin
               if (bus.divisor == 16'd0) w_state_nxt = S_DONE;
               else                      w_state_nxt = S_ITER;
            end
         end
         S_ITER:  if (w_last) w_state_nxt = S_DONE;
         S_DONE:  w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      w_busy = 1'b0;
      w_done = 1'b0;
      case (r_state)
         S_ITER:  w_busy = 1'b1;
         S_DONE: begin
            w_busy = 1'b1;
            w_done = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_rem  <= '0;
         r_div  <= '0;
         r_q    <= '0;
         r_cnt  <= '0;
         r_quot <= '0;
         r_remd <= '0;
         r_dbz  <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (bus.start) begin
                  if (bus.divisor != 16'd0) begin
                     r_rem <= {16'b0, bus.dividend};
                     r_div <= zero_shifter_16(bus.divisor);
                     r_q   <= '0;
                     r_cnt <= '0;
                     r_dbz <= 1'b0;
                  end else begin
                     r_quot <= DBZ_QUOT;
                     r_remd <= bus.dividend;
                     r_dbz  <= 1'b1;
                  end
               end
            end
            S_ITER: begin
               r_rem <= w_rem_nxt;
               r_q   <= w_q_nxt;
               r_div <= r_div >> 1;
               r_cnt <= r_cnt + 5'd1;
               if (w_last) begin
                  r_quot <= w_q_nxt[15:0];
                  r_remd <= w_rem_nxt[15:0];
               end
            end
            default: ;
         endcase
      end
   end

   // Dividend < divisor<<16 for any nonzero divisor, so the top quotient bit
   // can never be set.
   a_q_msb_zero: assert property (@(posedge clk) disable iff (reset) r_q[16] == 1'b0);

   assign bus.busy      = w_busy;
   assign bus.done      = w_done;
   assign bus.dbz       = r_dbz;
   assign bus.quotient  = r_quot;
   assign bus.remainder = r_remd;

endmodule

// File: tb/tb_seq_divider_ctrl_16.sv
module tb_seq_divider_ctrl_16;

   logic clk;
   logic reset;
   int   n_checks;
   int   n_errors;

   seq_divider_ctrl_16_if u_if ();

   seq_divider_ctrl_16 u_dut (
      .clk   (clk),
      .reset (reset),
      .bus   (u_if.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Called at a negedge in IDLE; start is accepted on the next posedge.
   // Operand inputs are scrambled after the accept edge to prove capture.
   task automatic run_div(input logic [15:0] a, input logic [15:0] b,
                          input logic [15:0] eq, input logic [15:0] er,
                          input logic edbz, input int elat);
      int lat;
      int bcnt;
      u_if.dividend = a;
      u_if.divisor  = b;
      u_if.start    = 1'b1;
      @(posedge clk);
      lat  = 0;
      bcnt = 0;
      for (int k = 1; k <= 40; k++) begin
         @(negedge clk);
         u_if.start    = 1'b0;
         u_if.dividend = 16'($urandom);
         u_if.divisor  = 16'($urandom);
         if (u_if.busy) bcnt++;
         if (u_if.done) begin
            lat = k;
            break;
         end
      end
      chk("latency", lat, elat);
      chk("busy_cycles", bcnt, elat);
      chk("quotient", u_if.quotient, eq);
      chk("remainder", u_if.remainder, er);
      chk("dbz", u_if.dbz, edbz);
      @(negedge clk);
      chk("done_width", u_if.done, 1'b0);
      chk("busy_after", u_if.busy, 1'b0);
   endtask

   initial begin
      int dcnt;
      logic [15:0] a;
      logic [15:0] b;
      n_checks      = 0;
      n_errors      = 0;
      reset         = 1'b1;
      u_if.start    = 1'b0;
      u_if.dividend = '0;
      u_if.divisor  = '0;
      repeat (2) @(negedge clk);
      chk("rst_busy", u_if.busy, 1'b0);
      chk("rst_done", u_if.done, 1'b0);
      chk("rst_dbz", u_if.dbz, 1'b0);
      chk("rst_quot", u_if.quotient, 16'd0);
      chk("rst_rem", u_if.remainder, 16'd0);
      reset = 1'b0;
      @(negedge clk);

      // 1: prior result, then abort mid-ITER with async reset
      run_div(16'd200, 16'd9, 16'd22, 16'd2, 1'b0, 18);
      u_if.dividend = 16'd100;
      u_if.divisor  = 16'd7;
      u_if.start    = 1'b1;
      @(posedge clk);
      @(negedge clk);
      u_if.start = 1'b0;
      repeat (4) @(negedge clk);
      #2 reset = 1'b1;
      #1;
      chk("abort_quot", u_if.quotient, 16'd0);
      chk("abort_rem", u_if.remainder, 16'd0);
      chk("abort_busy", u_if.busy, 1'b0);
      chk("abort_done", u_if.done, 1'b0);
      @(negedge clk);
      reset = 1'b0;
      dcnt  = 0;
      repeat (25) begin
         @(negedge clk);
         if (u_if.done) dcnt++;
      end
      chk("abort_no_done", dcnt, 0);
      run_div(16'd100, 16'd7, 16'd14, 16'd2, 1'b0, 18);

      // 2: divisor 1 and equal operands
      run_div(16'hFFFF, 16'h0001, 16'hFFFF, 16'd0, 1'b0, 18);
      run_div(16'hFFFF, 16'hFFFF, 16'd1, 16'd0, 1'b0, 18);

      // 3: dividend < divisor, zero dividend
      run_div(16'd5, 16'd9, 16'd0, 16'd5, 1'b0, 18);
      run_div(16'd0, 16'd3, 16'd0, 16'd0, 1'b0, 18);

      // 4: divide by zero, then a normal op clears dbz
      run_div(16'd1234, 16'd0, 16'hFFFF, 16'd1234, 1'b1, 1);
      run_div(16'd50, 16'd5, 16'd10, 16'd0, 1'b0, 18);

      // 5: starts during ITER and DONE are ignored
      u_if.dividend = 16'd1000;
      u_if.divisor  = 16'd3;
      u_if.start    = 1'b1;
      @(posedge clk);
      for (int k = 1; k <= 18; k++) begin
         @(negedge clk);
         if (k == 5 || k == 18) begin
            u_if.start    = 1'b1;
            u_if.dividend = 16'd7;
            u_if.divisor  = 16'd7;
         end else begin
            u_if.start = 1'b0;
         end
         if (k == 18) begin
            chk("ign_done", u_if.done, 1'b1);
            chk("ign_quot", u_if.quotient, 16'd333);
            chk("ign_rem", u_if.remainder, 16'd1);
         end
      end
      @(negedge clk);
      chk("ign_idle", u_if.busy, 1'b0);
      run_div(16'd7, 16'd7, 16'd1, 16'd0, 1'b0, 18);

      // 6: random sweep
      for (int i = 0; i < 2000; i++) begin
         a = 16'($urandom);
         if (i % 4 == 0) b = 16'($urandom_range(1, 15));
         else            b = 16'($urandom_range(1, 65535));
         run_div(a, b, a / b, a % b, 1'b0, 18);
         chk("invariant", 32'(u_if.quotient) * 32'(b) + 32'(u_if.remainder), 32'(a));
         chk("rem_lt_div", (u_if.remainder < b) ? 32'd1 : 32'd0, 32'd1);
         repeat ($urandom_range(0, 3)) @(negedge clk);
         chk("hold_quot", u_if.quotient, a / b);
         chk("hold_rem", u_if.remainder, a % b);
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/seq_divider_ctrl_16.md
Name: seq_divider_ctrl_16

Overview:
Multi-cycle restoring divider controller for the HW4 ALU datapath. It divides a 16-bit unsigned dividend by a 16-bit unsigned divisor using the Patterson "version 1" algorithm. The divisor is aligned into the upper half of a 32-bit divisor register through zero_shifter_16 (res = {a, 16'b0}); the remainder is 32 bits. The controller sequences load, subtract/test/restore and shift over 17 iterations, and returns quotient and remainder with a start/busy/done handshake.

Parameters:
DBZ_QUOT, 16'hFFFF, quotient value reported on divide-by-zero.
ITERS, 17, iteration count; fixed by the 16-bit width; must not be overridden.

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
start  input  1  request pulse; sampled only in IDLE
dividend  input  16  unsigned dividend; sampled with start
divisor  input  16  unsigned divisor; sampled with start
busy  output  1  high in ITER and DONE
done  output  1  one-cycle pulse; results valid
dbz  output  1  divide-by-zero flag; valid with done, held until next accepted start
quotient  output  16  result quotient; held until next accepted start
remainder  output  16  result remainder; held until next accepted start

Behaviour:
- Reset (async, active-high):
  - state=IDLE; busy=0, done=0, dbz=0.
  - quotient=0, remainder=0.
  - Internal rem_r, div_r, q_r and cnt are cleared.
- IDLE:
  - start=1 and divisor!=0 at edge T: rem_r={16'b0,dividend}; div_r=zero_shifter_16(divisor); q_r=0; cnt=0; dbz<=0; go to ITER.
  - start=1 and divisor==0 at edge T: quotient<=DBZ_QUOT; remainder<=dividend; dbz<=1; go to DONE. done is high in cycle T+1.
  - start=0: stay in IDLE; outputs hold.
- ITER (one cycle per iteration, 33-bit subtract):
  - diff = {1'b0,rem_r} - {1'b0,div_r}.
  - diff[32]==0: rem_r<=diff[31:0]; q_r<={q_r[15:0],1'b1}.
  - diff[32]==1: rem_r unchanged (restore); q_r<={q_r[15:0],1'b0}.
  - div_r<=div_r>>1 (logical); cnt<=cnt+1.
  - When cnt==16 the same edge writes quotient<=next q_r[15:0] and remainder<=next rem_r[15:0], then goes to DONE.
  - q_r is 17 bits internally. Bit 16 is always 0 because dividend < divisor<<16 for any nonzero divisor.
- DONE: done=1 for exactly one cycle; busy=1; next state IDLE unconditionally.
- Latency:
  - Normal divide: start accepted at edge T; 17 ITER cycles; done high during cycle T+18; busy high from T+1 through T+18.
  - Divide-by-zero: done high during cycle T+1.
- Back-to-back operation: start is not sampled in DONE. The earliest next accept is the first IDLE cycle, so the minimum issue interval is 19 cycles.
- start while busy (ITER or DONE) is ignored. The operation in flight and its inputs are unaffected; no queueing.
- dividend and divisor may change after the accept edge; they are captured only on that edge.
- Reset asserted mid-operation: immediate return to IDLE with all outputs 0. No done pulse for the aborted operation.
- dividend==0: normal path; quotient=0, remainder=0, latency 18.
- divisor==1: quotient=dividend, remainder=0.
- dividend<divisor: quotient=0, remainder=dividend.
- Invariant: for nonzero divisor, quotient*divisor + remainder == dividend and remainder < divisor.

Test Plan:
1. reset mid-ITER, then start 100/7 → outputs go to 0 asynchronously, no done pulse; next operation gives quotient=14, remainder=2, dbz=0, done exactly 18 cycles after accept, busy high 18 cycles.
2. 16'hFFFF / 16'h0001 → quotient=16'hFFFF, remainder=0. Then 16'hFFFF / 16'hFFFF → quotient=1, remainder=0.
3. 5/9 → quotient=0, remainder=5. Then 0/3 → quotient=0, remainder=0.
4. 1234/0 → done one cycle after accept, dbz=1, quotient=16'hFFFF, remainder=1234. A following 50/5 clears dbz and gives quotient=10, remainder=0.
5. Start 1000/3, then pulse start with 7/7 at cycles 5 and 18 after accept → both ignored; result quotient=333, remainder=1. A start in the first IDLE cycle is accepted.
6. Random sweep of 2000 pairs, divisor nonzero → check quotient*divisor + remainder == dividend, remainder < divisor, done width = 1 cycle, outputs stable until next accept.
